// File: rtl/tpu_seq_pkg.sv
// Shared types and helpers for the TPU layer sequencer: FSM state encoding,
// default widths and an index-to-one-hot helper.
package tpu_seq_pkg;

    localparam int NUM_LAYERS_DEF = 3;
    localparam int ADDR_W_DEF     = 11;
    localparam int CLASS_W_DEF    = 4;
    localparam int TIMEOUT_W_DEF  = 16;
    localparam int MAX_LAYERS     = 32;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        GAP,
        DONE,
        ERR
    } seq_state_e;

    // Callers truncate the result to their own layer count.
    function automatic logic [MAX_LAYERS-1:0] onehot(input int unsigned idx);
        return {{(MAX_LAYERS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/tpu_onehot_addr_mux.sv
// AND-OR select of per-layer ROM addresses by a one-hot enable; drives zero
// when no enable is set, so the shared ROM bus is never floating.
module tpu_onehot_addr_mux
    import tpu_seq_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic [NUM_LAYERS-1:0]        sel_i,
    input  logic [NUM_LAYERS*ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0]            addr_o
);

    logic [NUM_LAYERS-1:0][ADDR_W-1:0] masked;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_lane
        assign masked[g] = addr_i[g*ADDR_W +: ADDR_W] & {ADDR_W{sel_i[g]}};
    end

    always_comb begin
        addr_o = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            addr_o = addr_o | masked[i];
        end
    end

endmodule

// File: rtl/tpu_layer_sequencer.sv
// Runs NUM_LAYERS layer engines in order over a shared ROM and MultAdder.
// Optional watchdog enabled by defining TPU_SEQ_WATCHDOG_EN.
module tpu_layer_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CLASS_W    = CLASS_W_DEF,
    parameter int TIMEOUT_W  = TIMEOUT_W_DEF
) (
    input  logic                              clk,
    input  logic                              iRst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic [NUM_LAYERS-1:0]             layer_done,
    input  logic [NUM_LAYERS*ADDR_W-1:0]      layer_addr,
    input  logic [CLASS_W-1:0]                result_in,
    output logic [NUM_LAYERS-1:0]             layer_ena,
    output logic                              layer_rstn,
    output logic [ADDR_W-1:0]                 rom_addr,
    output logic [$clog2(NUM_LAYERS):0]       cur_layer,
    output logic [CLASS_W-1:0]                num_out,
    output logic                              busy,
    output logic                              done,
    output logic                              error
);

    localparam int CUR_W = $clog2(NUM_LAYERS) + 1;

    seq_state_e            state_q, state_d;
    logic [CUR_W-1:0]      cur_q, cur_d;
    logic [CLASS_W-1:0]    num_q, num_d;
    logic [NUM_LAYERS-1:0] cur_oh;
    logic                  cur_done;
    logic                  last_layer;
    logic                  wd_expired;

    assign cur_oh     = NUM_LAYERS'(onehot(32'(cur_q)));
    // Only the active engine's completion flag is honoured.
    assign cur_done   = |(layer_done & cur_oh);
    assign last_layer = (cur_q == CUR_W'(NUM_LAYERS - 1));

`ifdef TPU_SEQ_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (state_q == ARM) begin
            wd_d = '0;
        end else if (state_q == RUN) begin
            wd_d = wd_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    // Fires on the RUN cycle whose increment brings the counter to all-ones.
    assign wd_expired = (state_q == RUN) && (wd_q == ~TIMEOUT_W'(1));
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            num_q   <= num_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        num_d   = num_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_d = ARM;
                        cur_d   = '0;
                    end
                end
                ARM: state_d = RUN;
                RUN: begin
                    if (cur_done) begin
                        if (last_layer) begin
                            state_d = DONE;
                            num_d   = result_in;
                        end else begin
                            state_d = GAP;
                        end
                    end else if (wd_expired) begin
                        state_d = ERR;
                    end
                end
                GAP: begin
                    state_d = ARM;
                    cur_d   = cur_q + CUR_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Engines are held in reset during ARM so each layer starts clean.
    always_comb begin
        layer_ena  = '0;
        layer_rstn = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state_q)
            ARM: begin
                layer_ena = cur_oh;
                busy      = 1'b1;
            end
            RUN: begin
                layer_ena  = cur_oh;
                layer_rstn = 1'b1;
                busy       = 1'b1;
            end
            GAP:  busy = 1'b1;
            DONE: done = 1'b1;
`ifdef TPU_SEQ_WATCHDOG_EN
            ERR:  error = 1'b1;
`endif
            default: ;
        endcase
    end

    assign cur_layer = cur_q;
    assign num_out   = num_q;

    tpu_onehot_addr_mux #(
        .NUM_LAYERS (NUM_LAYERS),
        .ADDR_W     (ADDR_W)
    ) u_addr_mux (
        .sel_i  (layer_ena),
        .addr_i (layer_addr),
        .addr_o (rom_addr)
    );

endmodule

// File: tb/tb_tpu_layer_sequencer.sv
// Directed bench for tpu_layer_sequencer: three layers with latencies 5/7/4,
// spurious done flags, abort, back-to-back runs, async reset, watchdog.
module tb_tpu_layer_sequencer;

    logic        clk;
    logic        iRst_n;
    logic        start;
    logic        abort;
    logic [2:0]  layer_done;
    logic [32:0] layer_addr;
    logic [3:0]  result_in;
    logic [2:0]  layer_ena;
    logic        layer_rstn;
    logic [10:0] rom_addr;
    logic [2:0]  cur_layer;
    logic [3:0]  num_out;
    logic        busy;
    logic        done;
    logic        error;

    int nerr = 0;
    int nchk = 0;

    logic [2:0] eng_done;
    logic [2:0] inj;
    int         cnt[3];
    int         lat[3];

    tpu_layer_sequencer #(
        .NUM_LAYERS (3),
        .ADDR_W     (11),
        .CLASS_W    (4),
        .TIMEOUT_W  (4)
    ) dut (
        .clk        (clk),
        .iRst_n     (iRst_n),
        .start      (start),
        .abort      (abort),
        .layer_done (layer_done),
        .layer_addr (layer_addr),
        .result_in  (result_in),
        .layer_ena  (layer_ena),
        .layer_rstn (layer_rstn),
        .rom_addr   (rom_addr),
        .cur_layer  (cur_layer),
        .num_out    (num_out),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: counts RUN cycles, raises done when count hits latency.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            cnt[k] <= (layer_rstn && layer_ena[k]) ? cnt[k] + 1 : 0;
        end
    end

    always_comb begin
        eng_done = '0;
        for (int k = 0; k < 3; k++) begin
            eng_done[k] = layer_ena[k] && layer_rstn && (cnt[k] == lat[k]);
        end
        layer_done = eng_done | inj;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] exp_rom(input logic [2:0] ena);
        case (ena)
            3'b001:  return 11'h111;
            3'b010:  return 11'h222;
            3'b100:  return 11'h333;
            default: return 11'h000;
        endcase
    endfunction

    // Full 3-layer run; poke adds a spurious layer_done[2] and start while busy.
    task automatic run_seq(input bit poke, input logic [3:0] res, input logic [3:0] prev);
        logic [2:0] e_ena;
        logic       e_rstn;
        result_in = res;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 25; t++) begin
            e_ena  = (t <= 7)  ? 3'b001 : (t == 8)  ? 3'b000 :
                     (t <= 17) ? 3'b010 : (t == 18) ? 3'b000 :
                     (t <= 24) ? 3'b100 : 3'b000;
            e_rstn = (e_ena != 3'b000) && (t != 1) && (t != 9) && (t != 19);
            check("ena",  32'(layer_ena),  32'(e_ena));
            check("rstn", 32'(layer_rstn), 32'(e_rstn));
            check("busy", 32'(busy),       32'(t < 25));
            check("done", 32'(done),       32'(t == 25));
            check("num",  32'(num_out),    32'((t == 25) ? res : prev));
            check("rom",  32'(rom_addr),   32'(exp_rom(e_ena)));
            if (t < 25) begin
                if (poke) begin
                    inj   = (t >= 2 && t <= 5) ? 3'b100 : 3'b000;
                    start = (t >= 3 && t <= 5);
                end
                step();
            end
        end
        check("cur_end", 32'(cur_layer), 32'd2);
        check("err_end", 32'(error),     32'd0);
        inj   = '0;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        iRst_n     = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        inj        = '0;
        result_in  = 4'd0;
        layer_addr = {11'h333, 11'h222, 11'h111};
        lat[0] = 5; lat[1] = 7; lat[2] = 4;
        step();
        step();
        check("rst_ena",  32'(layer_ena),  32'd0);
        check("rst_rstn", 32'(layer_rstn), 32'd0);
        check("rst_cur",  32'(cur_layer),  32'd0);
        check("rst_num",  32'(num_out),    32'd0);
        check("rst_busy", 32'(busy),       32'd0);
        check("rst_done", 32'(done),       32'd0);
        check("rst_err",  32'(error),      32'd0);
        check("rst_rom",  32'(rom_addr),   32'd0);
        iRst_n = 1'b1;
        step();

        // Basic run, then back-to-back start from DONE, then spurious flags.
        run_seq(1'b0, 4'd7, 4'd0);
        step();
        check("done_hold", 32'(done), 32'd1);
        run_seq(1'b0, 4'd3, 4'd7);
        run_seq(1'b1, 4'd7, 4'd3);

        // Abort during RUN of layer 1.
        result_in = 4'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t < 12; t++) step();
        check("pre_abort_ena", 32'(layer_ena), 32'b010);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_ena",  32'(layer_ena), 32'd0);
        check("abort_busy", 32'(busy),      32'd0);
        check("abort_done", 32'(done),      32'd0);
        check("abort_num",  32'(num_out),   32'd7);
        check("abort_rom",  32'(rom_addr),  32'd0);
        step();
        run_seq(1'b0, 4'd5, 4'd7);

        // Abort then start in the same cycle from IDLE.
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", 32'(busy),      32'd0);
        check("sa_ena",  32'(layer_ena), 32'd0);
        step();
        check("sa_busy2", 32'(busy),     32'd0);
        check("sa_rom",   32'(rom_addr), 32'd0);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t < 14; t++) step();
        check("mid_cur", 32'(cur_layer), 32'd1);
        #3;
        iRst_n = 1'b0;
        #1;
        check("arst_ena",  32'(layer_ena), 32'd0);
        check("arst_busy", 32'(busy),      32'd0);
        check("arst_cur",  32'(cur_layer), 32'd0);
        check("arst_num",  32'(num_out),   32'd0);
        check("arst_rom",  32'(rom_addr),  32'd0);
        step();
        iRst_n = 1'b1;
        step();
        run_seq(1'b0, 4'd7, 4'd0);

        // Layer 0 never completes.
        lat[0] = 1000;
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef TPU_SEQ_WATCHDOG_EN
        for (int t = 1; t <= 17; t++) begin
            check("wd_ena",  32'(layer_ena), (t <= 16) ? 32'b001 : 32'd0);
            check("wd_err",  32'(error),     32'(t == 17));
            check("wd_busy", 32'(busy),      32'(t < 17));
            if (t < 17) step();
        end
        check("wd_rom",  32'(rom_addr), 32'd0);
        check("wd_done", 32'(done),     32'd0);
        step();
        check("err_hold", 32'(error), 32'd1);
`else
        for (int t = 1; t <= 20; t++) begin
            check("nowd_err", 32'(error),     32'd0);
            check("nowd_ena", 32'(layer_ena), 32'b001);
            step();
        end
`endif
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("clr_err",  32'(error),     32'd0);
        check("clr_ena",  32'(layer_ena), 32'd0);
        check("clr_rom",  32'(rom_addr),  32'd0);
        lat[0] = 5;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/tpu_layer_sequencer.md
Name: tpu_layer_sequencer

Overview:
- Parametrised layer sequencer for the DNN accelerator; replaces the fixed three-layer TPU control FSM.
- Runs NUM_LAYERS fully-connected layer engines one at a time, in order, over one shared weight ROM and one shared MultAdder.
- Uses a start/done handshake, supports abort, and has an optional watchdog.
- Drives a non-tristate one-hot mux of layer ROM addresses and captures the final argmax class index.

Parameters:
NUM_LAYERS, 3, number of sequential layer engines (≥1)
ADDR_W, 11, ROM address width per layer engine
CLASS_W, 4, width of class index from argmax
TIMEOUT_W, 16, watchdog counter width (used only with watchdog)

Ports:
clk  in  1  clock
iRst_n  in  1  reset, asynchronous, active-low
start  in  1  request inference; sampled only in IDLE/DONE/ERR
abort  in  1  synchronous abort; priority over start
layer_done  in  NUM_LAYERS  per-layer completion flags
layer_addr  in  NUM_LAYERS*ADDR_W  packed ROM addresses from layers, layer 0 in LSBs
result_in  in  CLASS_W  argmax index of last layer output
layer_ena  out  NUM_LAYERS  one-hot enable of active layer
layer_rstn  out  1  active-low sync reset shared by layers
rom_addr  out  ADDR_W  address of active layer; 0 when none active
cur_layer  out  $clog2(NUM_LAYERS)+1  index of active layer
num_out  out  CLASS_W  classified digit
busy  out  1  sequence in progress
done  out  1  result valid, level
error  out  1  watchdog fired

Behaviour:
- Reset: state=IDLE, layer_ena=0, layer_rstn=0, cur_layer=0, num_out=0, busy=0, done=0, error=0, rom_addr=0.
- States: IDLE, ARM, RUN, GAP, DONE, ERR.
- IDLE/DONE/ERR + start=1 → ARM, cur_layer=0, busy=1, done=0, error=0. num_out holds its old value until new capture.
- ARM (1 cycle): layer_ena=one-hot(cur_layer), layer_rstn=0 → RUN.
- RUN: layer_rstn=1. Wait for layer_done[cur_layer]=1; layer_done bits of non-active layers are ignored.
  - On done with cur_layer<NUM_LAYERS-1: layer_ena=0, layer_rstn=0 → GAP.
  - On done with cur_layer=NUM_LAYERS-1: num_out<=result_in, layer_ena=0, layer_rstn=0, busy=0, done=1 → DONE.
- GAP (1 cycle, all engines idle, shared bus quiet): cur_layer+=1 → ARM.
- DONE: done stays high until start or abort.
- Per-layer overhead: 3 cycles (ARM, RUN entry, GAP). Last layer: 2 cycles plus its compute time.
- abort=1 in any state: next cycle IDLE, layer_ena=0, layer_rstn=0, busy=0, done=0, error=0; num_out unchanged. Abort wins over start in the same cycle.
- start while busy: ignored.
- Mid-run async reset: immediate return to reset values.
- rom_addr: combinational AND-OR select of layer_addr slices by layer_ena; 0 when layer_ena=0. Never high-Z.
- NUM_LAYERS=1: ARM→RUN→DONE, GAP never entered.

Optional Feature:
- Macro: TPU_SEQ_WATCHDOG_EN.
- With the macro:
  - A TIMEOUT_W counter clears in ARM and increments each RUN cycle.
  - On reaching all-ones without layer_done: layer_ena=0, layer_rstn=0, busy=0, error=1, done=0 → ERR.
  - ERR is left only by start or abort.
- Without the macro: no counter; error is tied 0 and ERR is unreachable.

Decomposition:
- Package tpu_seq_pkg holds:
  - state enum (IDLE, ARM, RUN, GAP, DONE, ERR);
  - function returning one-hot from index;
  - default width constants.
- One sub-module, tpu_onehot_addr_mux (parametrised NUM_LAYERS, ADDR_W), implements the rom_addr select.

Test Plan:
- NUM_LAYERS=3, layer_done pulses after 5/7/4 RUN cycles, result_in=7:
  - layer_ena sequence 001,010,100;
  - done=1 and num_out=7 at cycle 25 after start;
  - busy low the same cycle.
- layer_done[2] asserted while layer 0 active → ignored; sequence unchanged.
- abort in RUN of layer 1 → next cycle IDLE, layer_ena=0, busy=0; a later start re-runs from layer 0.
- start and abort in the same cycle from IDLE → remains IDLE.
- Back-to-back: start in DONE with result_in=3 → done drops next cycle, num_out=3 after the run.
- TPU_SEQ_WATCHDOG_EN, TIMEOUT_W=4, layer 0 never done → error=1 after 15 RUN cycles, layer_ena=0; rom_addr=0 throughout idle.
